ram2rw_ctl: RTL

Parametrised single-clock true dual-port RAM for the STM-1/E1 mapper datapath, successor to the dual-clock dual-port RAM model. It adds:
- deterministic write-collision arbitration;
- a selectable read-during-write policy;
- an optional output register stage;
- an address-range check;
- a hardware clear sequencer that fills the array after reset or on request.

It buffers per-channel E1 overhead and pointer state shared by two independent engines.

---
 rtl/ram_pkg.sv | 11 +
 rtl/ram2rw_ctl_if.sv | 17 +
 rtl/ram2rw_clrseq.sv | 62 ++++++
 rtl/ram2rw_ctl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared encodings for the single-clock dual-port RAM controller:
// read-during-write policy, write-collision priority and clear FSM states.
package ram_pkg;

    typedef enum logic {RDW_OLD, RDW_NEW} rdw_e;

    typedef enum logic {PRI_A, PRI_B} pri_e;

    typedef enum logic {StIdle, StClear} clr_state_e;

endpackage

// File: rtl/ram2rw_ctl_if.sv
// Two-port RAM access bus: address, write enable, write data and read data per port.
interface ram2rw_ctl_if #(
    parameter int unsigned ADDRBIT = 11,
    parameter int unsigned WIDTH   = 32
);
    logic [ADDRBIT-1:0] a0;
    logic               we0;
    logic [WIDTH-1:0]   di0;
    logic [WIDTH-1:0]   do0;
    logic [ADDRBIT-1:0] a1;
    logic               we1;
    logic [WIDTH-1:0]   di1;
    logic [WIDTH-1:0]   do1;

    modport master (output a0, we0, di0, a1, we1, di1, input do0, do1);
    modport slave  (input a0, we0, di0, a1, we1, di1, output do0, do1);
endinterface

// File: rtl/ram2rw_clrseq.sv
// Clear sequencer: walks every word after reset or on init_req, writing INIT_VAL
// through an internal write port that the top muxes onto port A.
module ram2rw_clrseq
    import ram_pkg::*;
#(
    parameter int unsigned     ADDRBIT  = 11,
    parameter int unsigned     DEPTH    = 1536,
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_req,
    output logic               busy,
    output logic               clr_we,
    output logic [ADDRBIT-1:0] clr_addr,
    output logic [WIDTH-1:0]   clr_wdata
);
    localparam logic [ADDRBIT-1:0] LastPtr = ADDRBIT'(DEPTH - 1);

    clr_state_e         state_q, state_d;
    logic [ADDRBIT-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        unique case (state_q)
            StClear: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (ptr_q == LastPtr) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDRBIT'(1);
                end
            end
            StIdle: begin
                if (init_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    assign clr_addr  = ptr_q;
    assign clr_wdata = INIT_VAL;

endmodule

// File: rtl/ram2rw_ctl.sv
// Single-clock true dual-port RAM with collision arbitration, read-during-write
// bypass, optional output register, address-range check and hardware clear.
module ram2rw_ctl
    import ram_pkg::*;
#(
    parameter int unsigned      ADDRBIT     = 11,
    parameter int unsigned      DEPTH       = 1536,
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      OUTREG      = 0,
    parameter string            RDW_MODE    = "OLD",
    parameter string            COLLIDE_PRI = "A",
    parameter logic [WIDTH-1:0] INIT_VAL    = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    output logic        busy,
    ram2rw_ctl_if.slave bus,
    output logic        coll_wr,
    output logic [15:0] coll_cnt,
    output logic        addr_err
);
    localparam int unsigned MemAw  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam rdw_e        RdwSel = (RDW_MODE == "NEW") ? RDW_NEW : RDW_OLD;
    localparam pri_e        PriSel = (COLLIDE_PRI == "B") ? PRI_B : PRI_A;

    logic               clr_we;
    logic [ADDRBIT-1:0] clr_addr;
    logic [WIDTH-1:0]   clr_wdata;

    ram2rw_clrseq #(
        .ADDRBIT  (ADDRBIT),
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .INIT_VAL (INIT_VAL)
    ) u_clrseq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_req  (init_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .clr_wdata (clr_wdata)
    );

    logic [WIDTH-1:0]   mem [DEPTH];
    logic               in0, in1, same, coll;
    logic               wr0, wr1, rd0, rd1, we_a;
    logic [ADDRBIT-1:0] wa_addr;
    logic [WIDTH-1:0]   wa_data, rdata0, rdata1;
    logic [WIDTH-1:0]   rd0_q, rd1_q;
    logic               coll_wr_q, addr_err_q;
    logic [15:0]        coll_cnt_q;

    always_comb begin
        in0  = 32'(bus.a0) < DEPTH;
        in1  = 32'(bus.a1) < DEPTH;
        same = bus.a0 == bus.a1;
        // Out-of-range writes are already dropped, so they never collide.
        coll = !busy && bus.we0 && bus.we1 && in0 && in1 && same;
        wr0  = !busy && bus.we0 && in0 && !(coll && PriSel == PRI_B);
        wr1  = !busy && bus.we1 && in1 && !(coll && PriSel == PRI_A);
        rd0  = !busy && !bus.we0;
        rd1  = !busy && !bus.we1;

        we_a    = clr_we || wr0;
        wa_addr = busy ? clr_addr : bus.a0;
        wa_data = busy ? clr_wdata : bus.di0;

        rdata0 = '0;
        if (in0) begin
            if (RdwSel == RDW_NEW && wr1 && same) rdata0 = bus.di1;
            else                                  rdata0 = mem[bus.a0[MemAw-1:0]];
        end
        rdata1 = '0;
        if (in1) begin
            if (RdwSel == RDW_NEW && wr0 && same) rdata1 = bus.di0;
            else                                  rdata1 = mem[bus.a1[MemAw-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (we_a) mem[wa_addr[MemAw-1:0]] <= wa_data;
        if (wr1)  mem[bus.a1[MemAw-1:0]]  <= bus.di1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || busy) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            if (rd0) rd0_q <= rdata0;
            if (rd1) rd1_q <= rdata1;
        end
    end

    if (OUTREG != 0) begin : g_outreg
        logic [WIDTH-1:0] out0_q, out1_q;
        always_ff @(posedge clk) begin
            if (!rst_n || busy) begin
                out0_q <= '0;
                out1_q <= '0;
            end else begin
                out0_q <= rd0_q;
                out1_q <= rd1_q;
            end
        end
        assign bus.do0 = out0_q;
        assign bus.do1 = out1_q;
    end else begin : g_direct
        assign bus.do0 = rd0_q;
        assign bus.do1 = rd1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_wr_q  <= 1'b0;
            coll_cnt_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            coll_wr_q <= coll;
            if (coll && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
            if (busy)                     addr_err_q <= 1'b0;
            else if (!in0 || !in1)        addr_err_q <= 1'b1;
        end
    end

    assign coll_wr  = coll_wr_q;
    assign coll_cnt = coll_cnt_q;
    assign addr_err = addr_err_q;

endmodule
